// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared image geometry constants and writer state encoding
package image_pkg;

  localparam int IMG_ROWS   = 28;
  localparam int IMG_COLS   = 28;
  localparam int IMG_PIXELS = IMG_ROWS * IMG_COLS;
  localparam int IDX_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/frame_dilate.sv
// rtl/frame_dilate.sv - combinational plus-shaped dilation of a 28x28 binary frame
module frame_dilate
  import image_pkg::*;
(
  input  logic [IMG_PIXELS-1:0] i_frame,
  output logic [IMG_PIXELS-1:0] o_frame
);

  // Each output pixel ORs itself with its in-image 4-neighbours; edges see 0, no row wrap.
  for (genvar r = 0; r < IMG_ROWS; r++) begin : g_row
    for (genvar c = 0; c < IMG_COLS; c++) begin : g_col
      localparam int I = r * IMG_COLS + c;
      logic w_left, w_right, w_up, w_down;

      if (c > 0) begin : g_l
        assign w_left = i_frame[I-1];
      end else begin : g_l_edge
        assign w_left = 1'b0;
      end

      if (c < IMG_COLS - 1) begin : g_r
        assign w_right = i_frame[I+1];
      end else begin : g_r_edge
        assign w_right = 1'b0;
      end

      if (r > 0) begin : g_u
        assign w_up = i_frame[I-IMG_COLS];
      end else begin : g_u_edge
        assign w_up = 1'b0;
      end

      if (r < IMG_ROWS - 1) begin : g_d
        assign w_down = i_frame[I+IMG_COLS];
      end else begin : g_d_edge
        assign w_down = 1'b0;
      end

      assign o_frame[I] = i_frame[I] | w_left | w_right | w_up | w_down;
    end
  end

endmodule

// File: rtl/image_frame_writer.sv
// rtl/image_frame_writer.sv - thresholds a 28x28 pixel stream into a 784-bit frame and strobes init (option: IMAGE_FRAME_WRITER_DILATE_EN)
module image_frame_writer
  import image_pkg::*;
#(
  parameter int THRESHOLD = 128,
  parameter int PIX_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pix_valid,
  output logic                  o_pix_ready,
  input  logic                  i_pix_sop,
  input  logic [PIX_W-1:0]      i_pix_data,
  output logic [IMG_PIXELS-1:0] o_pixel_data,
  output logic                  o_init,
  output logic                  o_frame_done,
  output logic                  o_busy,
  output logic [15:0]           o_frame_count,
  output logic [15:0]           o_drop_count
);

  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(IMG_PIXELS - 1);
  localparam logic [PIX_W:0]   LP_THR  = THRESHOLD[PIX_W:0];

  state_t                  r_state, r_state_next;
  logic [IMG_PIXELS-1:0]   r_fill;
  logic [IMG_PIXELS-1:0]   r_pixel_data;
  logic [IDX_W-1:0]        r_idx;
  logic [15:0]             r_frame_count;
  logic [15:0]             r_drop_count;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_bit;
  logic [16:0]             w_drop_sum;
  logic [IMG_PIXELS-1:0]   w_frame;
  logic [IMG_PIXELS-1:0]   w_commit;

  // Ready depends on state only, so there is no path from valid back to ready.
  assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_FILL);
  assign w_accept   = i_pix_valid & w_ready;
  assign w_bit      = ({1'b0, i_pix_data} >= LP_THR);
  assign w_drop_sum = {1'b0, r_drop_count} + {{(17-IDX_W){1'b0}}, r_idx};

  // Frame as it will look once the final sample lands in bit 783.
  always_comb begin
    w_frame                 = r_fill;
    w_frame[IMG_PIXELS-1]   = w_bit;
  end

`ifdef IMAGE_FRAME_WRITER_DILATE_EN
  frame_dilate u_dilate (
    .i_frame (w_frame),
    .o_frame (w_commit)
  );
`else
  assign w_commit = w_frame;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= r_state_next;
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    r_state_next = r_state;
    o_init       = 1'b0;
    o_frame_done = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_accept && i_pix_sop) r_state_next = ST_FILL;
      ST_FILL:   if (w_accept && !i_pix_sop && r_idx == LP_LAST) r_state_next = ST_COMMIT;
      ST_COMMIT: begin
        o_init       = 1'b1;
        r_state_next = ST_DONE;
      end
      ST_DONE: begin
        o_frame_done = 1'b1;
        r_state_next = ST_IDLE;
      end
      default:   r_state_next = ST_IDLE;
    endcase
  end

  // Fill buffer, pixel index, shadow frame and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill        <= '0;
      r_pixel_data  <= '0;
      r_idx         <= '0;
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (i_pix_sop) begin
              r_fill <= {{(IMG_PIXELS-1){1'b0}}, w_bit};
              r_idx  <= IDX_W'(1);
            end else if (r_drop_count != 16'hFFFF) begin
              r_drop_count <= r_drop_count + 16'd1;
            end
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            if (i_pix_sop) begin
              // Restart: the partial frame's pixels count as dropped samples.
              r_fill       <= {{(IMG_PIXELS-1){1'b0}}, w_bit};
              r_idx        <= IDX_W'(1);
              r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end else if (r_idx == LP_LAST) begin
              r_pixel_data <= w_commit;
            end else begin
              r_fill[r_idx] <= w_bit;
              r_idx         <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_COMMIT: r_frame_count <= r_frame_count + 16'd1;
        ST_DONE: begin
          r_fill <= '0;
          r_idx  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_pix_ready   = w_ready;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_pixel_data  = r_pixel_data;
  assign o_frame_count = r_frame_count;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_image_frame_writer.sv
// tb/tb_image_frame_writer.sv - directed self-checking bench for image_frame_writer (option: IMAGE_FRAME_WRITER_DILATE_EN)
module tb_image_frame_writer;

  localparam int NPIX = 784;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_pix_valid = 1'b0;
  logic            o_pix_ready;
  logic            i_pix_sop = 1'b0;
  logic [7:0]      i_pix_data = 8'h00;
  logic [NPIX-1:0] o_pixel_data;
  logic            o_init;
  logic            o_frame_done;
  logic            o_busy;
  logic [15:0]     o_frame_count;
  logic [15:0]     o_drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_init = 0;
  int n_overlap = 0;

  image_frame_writer #(.THRESHOLD(128), .PIX_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pix_valid   (i_pix_valid),
    .o_pix_ready   (o_pix_ready),
    .i_pix_sop     (i_pix_sop),
    .i_pix_data    (i_pix_data),
    .o_pixel_data  (o_pixel_data),
    .o_init        (o_init),
    .o_frame_done  (o_frame_done),
    .o_busy        (o_busy),
    .o_frame_count (o_frame_count),
    .o_drop_count  (o_drop_count)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (o_init) n_init++;
    if (o_init && o_frame_done) n_overlap++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [NPIX-1:0] obs, input logic [NPIX-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [NPIX-1:0] dil(input logic [NPIX-1:0] f);
    logic [NPIX-1:0] o;
    o = f;
`ifdef IMAGE_FRAME_WRITER_DILATE_EN
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        if (c > 0  && f[r*28+c-1])   o[r*28+c] = 1'b1;
        if (c < 27 && f[r*28+c+1])   o[r*28+c] = 1'b1;
        if (r > 0  && f[(r-1)*28+c]) o[r*28+c] = 1'b1;
        if (r < 27 && f[(r+1)*28+c]) o[r*28+c] = 1'b1;
      end
    end
`endif
    return o;
  endfunction

  function automatic logic [7:0] pix(input int mode, input int i);
    case (mode)
      0:       return (i % 2 == 0) ? 8'hFF : 8'h00;
      1:       return (i % 2 == 0) ? 8'h00 : 8'hFF;
      2:       return 8'hFF;
      3:       return 8'h00;
      4:       return (i == 0) ? 8'd127 : ((i == 1) ? 8'd128 : 8'd0);
      default: return (i == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    i_pix_valid = 1'b0;
    i_pix_sop = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic sop, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    t = 0;
    while (!o_pix_ready && t < 8) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 8) begin
      n_checks++;
      n_errors++;
      $error("FAIL ready_wait: observed ready 0 for 8 cycles expected 1");
    end
    i_pix_valid = 1'b1;
    i_pix_data  = d;
    i_pix_sop   = sop;
    @(posedge clk);
    #1;
    i_pix_valid = 1'b0;
    i_pix_sop   = 1'b0;
  endtask

  task automatic send_range(input int mode, input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++)
      send(pix(mode, i), (i == 0), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
  endtask

  task automatic expect_commit(input logic [NPIX-1:0] exp, input logic [15:0] fc);
    chk("init_n1", o_init, 1);
    chk("pixel_data_n1", o_pixel_data, exp);
    chk("frame_done_n1", o_frame_done, 0);
    chk("ready_n1", o_pix_ready, 0);
    @(posedge clk);
    #1;
    chk("frame_done_n2", o_frame_done, 1);
    chk("init_n2", o_init, 0);
    chk("frame_count_n2", o_frame_count, fc);
    chk("pixel_data_n2", o_pixel_data, exp);
    @(posedge clk);
    #1;
    chk("ready_n3", o_pix_ready, 1);
    chk("busy_n3", o_busy, 0);
    chk("pixel_data_n3", o_pixel_data, exp);
  endtask

  logic [NPIX-1:0] e_alt, e_alt_inv, e_ones, e_thr, e_single, e_sop784;
  int init_base;

  initial begin
    e_alt     = {392{2'b01}};
    e_alt_inv = {392{2'b10}};
    e_ones    = '1;
    e_thr     = 784'd2;
    e_single  = 784'd1;
    e_sop784  = ~784'd1;

    // Reset state
    do_reset();
    chk("rst_ready", o_pix_ready, 1);
    chk("rst_init", o_init, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_frame_count", o_frame_count, 0);
    chk("rst_drop_count", o_drop_count, 0);
    chk("rst_pixel_data", o_pixel_data, 0);

    // Alternating 0xFF/0x00 frame, no stalls
    send_range(0, 0, 783, 0);
    expect_commit(dil(e_alt), 16'd1);

    // Threshold edge 127/128, with the previous frame held during fill
    send_range(4, 0, 399, 0);
    chk("hold_during_fill", o_pixel_data, dil(e_alt));
    chk("busy_fill", o_busy, 1);
    send_range(4, 400, 783, 0);
    expect_commit(dil(e_thr), 16'd2);

    // Five samples without sop in IDLE are dropped
    for (int k = 0; k < 5; k++) send(8'hFF, 1'b0, 0);
    chk("idle_drops", o_drop_count, 5);
    chk("idle_busy", o_busy, 0);
    send_range(1, 0, 783, 0);
    expect_commit(dil(e_alt_inv), 16'd3);
    chk("drops_after_frame", o_drop_count, 5);

    // Restart after 300 samples
    do_reset();
    init_base = n_init;
    send_range(3, 0, 299, 0);
    send_range(2, 0, 783, 0);
    expect_commit(dil(e_ones), 16'd1);
    chk("restart_drops", o_drop_count, 300);
    chk("restart_init_once", n_init - init_base, 1);

    // Reset in the middle of a frame
    send_range(2, 0, 499, 0);
    chk("hold_before_reset", o_pixel_data, dil(e_ones));
    do_reset();
    chk("midreset_pixel_data", o_pixel_data, 0);
    chk("midreset_frame_count", o_frame_count, 0);
    send_range(3, 0, 783, 0);
    expect_commit(784'd0, 16'd1);
    chk("midreset_drops", o_drop_count, 0);

    // sop on the 784th sample is a restart, not a completion
    init_base = n_init;
    send_range(2, 0, 782, 0);
    send(8'h00, 1'b1, 0);
    chk("sop784_drops", o_drop_count, 783);
    chk("sop784_busy", o_busy, 1);
    chk("sop784_no_init", n_init - init_base, 0);
    send_range(2, 1, 783, 0);
    expect_commit(dil(e_sop784), 16'd2);

    // Single pixel at (0,0)
    send_range(5, 0, 783, 0);
`ifdef IMAGE_FRAME_WRITER_DILATE_EN
    expect_commit((784'd1 << 0) | (784'd1 << 1) | (784'd1 << 28), 16'd3);
`else
    expect_commit(e_single, 16'd3);
`endif

    // Random valid gaps give the same frame as the gap-free run
    send_range(0, 0, 783, 2);
    expect_commit(dil(e_alt), 16'd4);

    chk("init_frame_done_overlap", n_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
